stp_fsm: RTL and testbench
==========================

Name: stp_fsm

Overview:
- Store-Polynomial (STP) instruction engine; sits directly upstream of the polynomial-evaluation FSM.
- Pulls N+1 coefficients for polynomial slot A from the shared input data buffer.
- Writes them into the coefficient memory S (8 slots × 11 words, slot base A*11) and writes the degree into the N memory.
- The evaluator later reads S and N for that slot.

Parameters:
- word_size, 16, coefficient width written to S.
- buffer_size, 1024, input data buffer depth; address width = log2(buffer_size).
- max_degree, 10, largest legal degree; slot stride = max_degree+1 = 11.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rst_instr  in  1  active-low synchronous instruction abort.
- start_stp  in  1  start pulse, sampled in IDLE.
- A  in  3  target polynomial slot 0..7.
- N_in  in  5  requested degree.
- rd_addr_data  in  log2(buffer_size)  buffer address of the first coefficient.
- data_in  in  32  buffer read data; valid the cycle after en_rd_data.
- en_rd_data  out  1  buffer read enable.
- rd_addr_data_out  out  log2(buffer_size)  buffer read address.
- rd_addr_data_updated  out  log2(buffer_size)  next free read address after the instruction.
- en_wr_S  out  1  S write enable.
- wr_addr_S  out  7  S write address.
- wr_data_S  out  word_size  S write data.
- en_wr_N  out  1  N write enable.
- wr_addr_N  out  3  N write address.
- wr_data_N  out  5  N write data.
- done_stp  out  1  instruction complete.
- status  out  32  0 = OK, 1 = invalid degree.

Behaviour:
- Reset (rst=1, async): state IDLE. All outputs 0, including rd_addr_data_updated and status.
- States: IDLE, CHECK_N, RD_COEF, WR_COEF, WR_N, DONE.
- IDLE:
  - start_stp=1 latches A, N_in and rd_addr_data, clears coefficient counter i, and moves to CHECK_N.
- CHECK_N:
  - N>max_degree: status=1, no memory writes, rd_addr_data_updated=rd_addr_data, go to DONE.
  - Otherwise go to RD_COEF.
- RD_COEF:
  - en_rd_data=1 and rd_addr_data_out=(base+i) mod buffer_size; go to WR_COEF.
- WR_COEF:
  - en_wr_S=1, wr_addr_S=A*11+i, wr_data_S=data_in[word_size-1:0] (truncation, no saturation).
  - If i==N go to WR_N; otherwise i++ and go to RD_COEF.
- WR_N:
  - en_wr_N=1, wr_addr_N=A, wr_data_N=N.
  - rd_addr_data_updated=(base+N+1) mod buffer_size; status=0; go to DONE.
- DONE:
  - done_stp=1 held; status and rd_addr_data_updated held.
  - start_stp=1 begins a new instruction directly: latch inputs, go to CHECK_N, drop done_stp.
- Enables are single-cycle, combinational from state; all other outputs are registered.
- Latency: a valid instruction raises done_stp 2N+4 cycles after the start edge; an invalid one after 2 cycles.
- Buffer address wraps modulo buffer_size, e.g. base 1023, N=1 reads addresses 1023 then 0.
- rst_instr=0 in any state: go to IDLE next edge.
  - Clears done_stp, status and all enables.
  - Holds rd_addr_data_updated.
  - An aborted instruction may leave a partial S write; N is not written.
- start_stp outside IDLE/DONE is ignored.
- rst has priority over rst_instr and start_stp.

Optional Feature:
- Macro STP_CLEAR_UNUSED_EN.
- Defined: after the last WR_COEF, a CLEAR state writes 0 to S[A*11+N+1 .. A*11+10], one word per cycle, then goes to WR_N. Latency becomes 2N+4+(10-N).
- Undefined: unused slot words are left untouched.

Test Plan:
- A=1, N_in=0, rd_addr_data=1, buffer[1]=25432: S[11]=25432, N[1]=0, status=0, rd_addr_data_updated=2, done_stp high 4 cycles after start.
- A=7, N_in=10, base=100, buffer[100..110]=1..11: S[77..87]=1..11, N[7]=10, rd_addr_data_updated=111, done after 24 cycles.
- N_in=11: no en_wr_S/en_wr_N pulses, status=1, done after 2 cycles, rd_addr_data_updated=base.
- base=1023, N_in=1, buffer[1023]=5, buffer[0]=6: reads 1023 then 0, S[A*11]=5, S[A*11+1]=6, rd_addr_data_updated=1.
- rst_instr=0 during the second RD_COEF of an N=3 instruction: IDLE next edge, en_wr_N never asserted, done_stp=0, rd_addr_data_updated unchanged.
- rst=1 asserted mid-WR_COEF (between edges): all outputs 0 immediately; with STP_CLEAR_UNUSED_EN, N=2 on slot 0 zeroes S[3..10].

Source files
------------

// File: rtl/stp_fsm.sv
// -----------------------------------------------------------------------------
// stp_fsm -- Store-Polynomial instruction engine
//
// Copies the N+1 coefficients of polynomial slot A from the shared input data
// buffer into coefficient memory S (8 slots x (max_degree+1) words, slot base
// A*(max_degree+1)), then records the degree in the N memory. The downstream
// polynomial evaluator reads S and N for that slot afterwards.
//
// Build option:
//   STP_CLEAR_UNUSED_EN  when defined, the slot words above the degree
//                        (A*11+N+1 .. A*11+10) are zeroed before N is written.
//                        When undefined those words are left untouched.
//
// Ports:
//   clk                   system clock, rising edge
//   rst                   asynchronous active-high reset
//   rst_instr             active-low synchronous instruction abort
//   start_stp             start pulse, accepted in IDLE or DONE
//   A                     target polynomial slot 0..7
//   N_in                  requested degree
//   rd_addr_data          buffer address of the first coefficient
//   data_in               buffer read data, valid the cycle after en_rd_data
//   en_rd_data            buffer read enable
//   rd_addr_data_out      buffer read address
//   rd_addr_data_updated  next free buffer address after the instruction
//   en_wr_S / wr_addr_S / wr_data_S   coefficient memory write port
//   en_wr_N / wr_addr_N / wr_data_N   degree memory write port
//   done_stp              instruction complete (held in DONE)
//   status                0 = OK, 1 = invalid degree
// -----------------------------------------------------------------------------
module stp_fsm #(
   parameter int word_size   = 16,
   parameter int buffer_size = 1024,
   parameter int max_degree  = 10
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rst_instr,
   input  logic                           start_stp,
   input  logic [2:0]                     A,
   input  logic [4:0]                     N_in,
   input  logic [$clog2(buffer_size)-1:0] rd_addr_data,
   input  logic [31:0]                    data_in,
   output logic                           en_rd_data,
   output logic [$clog2(buffer_size)-1:0] rd_addr_data_out,
   output logic [$clog2(buffer_size)-1:0] rd_addr_data_updated,
   output logic                           en_wr_S,
   output logic [6:0]                     wr_addr_S,
   output logic [word_size-1:0]           wr_data_S,
   output logic                           en_wr_N,
   output logic [2:0]                     wr_addr_N,
   output logic [4:0]                     wr_data_N,
   output logic                           done_stp,
   output logic [31:0]                    status
);

   localparam int AW = $clog2(buffer_size);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CHECK_N = 3'd1;
   localparam logic [2:0] RD_COEF = 3'd2;
   localparam logic [2:0] WR_COEF = 3'd3;
   localparam logic [2:0] WR_N    = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;
`ifdef STP_CLEAR_UNUSED_EN
   localparam logic [2:0] CLEAR   = 3'd6;
`endif

   logic [2:0]    state_reg;
   logic [2:0]    a_reg;
   logic [4:0]    n_reg;
   logic [AW-1:0] base_reg;
   logic [4:0]    i_reg;
   logic [AW-1:0] rd_addr_out_reg;
   logic [AW-1:0] upd_reg;
   logic [6:0]    wr_addr_s_reg;
   logic          status_reg;
   logic          done_reg;

   logic [6:0]    slot_base;
   logic [4:0]    i_inc;
   logic [AW-1:0] rd_next_addr;
   logic [AW-1:0] upd_valid;
   logic          n_invalid;
   logic          unused_data;

   assign slot_base    = 7'(a_reg) * 7'(max_degree + 1);
   assign i_inc        = i_reg + 5'd1;
   // Buffer addresses wrap naturally because the sum is truncated to AW bits
   // (buffer_size is a power of two).
   assign rd_next_addr = base_reg + AW'(i_inc);
   assign upd_valid    = base_reg + AW'(n_reg) + AW'(1);
   assign n_invalid    = (n_reg > 5'(max_degree));

   // Only the low word_size bits are stored; the rest of the bus is ignored.
   assign unused_data  = ^data_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         a_reg           <= '0;
         n_reg           <= '0;
         base_reg        <= '0;
         i_reg           <= '0;
         rd_addr_out_reg <= '0;
         upd_reg         <= '0;
         wr_addr_s_reg   <= '0;
         status_reg      <= 1'b0;
         done_reg        <= 1'b0;
      end else if (!rst_instr) begin
         // Abort: rd_addr_data_updated keeps the last committed value so the
         // buffer read pointer is not disturbed by a cancelled instruction.
         state_reg  <= IDLE;
         i_reg      <= '0;
         status_reg <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_stp) begin
                  a_reg     <= A;
                  n_reg     <= N_in;
                  base_reg  <= rd_addr_data;
                  i_reg     <= '0;
                  state_reg <= CHECK_N;
               end
            end

            CHECK_N: begin
               if (n_invalid) begin
                  status_reg <= 1'b1;
                  upd_reg    <= base_reg;
                  state_reg  <= DONE;
               end else begin
                  rd_addr_out_reg <= base_reg;
                  state_reg       <= RD_COEF;
               end
            end

            RD_COEF: begin
               // Address is set up now so it is stable while the read data
               // arrives during WR_COEF.
               wr_addr_s_reg <= slot_base + 7'(i_reg);
               state_reg     <= WR_COEF;
            end

            WR_COEF: begin
               if (i_reg == n_reg) begin
`ifdef STP_CLEAR_UNUSED_EN
                  if (n_reg < 5'(max_degree)) begin
                     i_reg         <= i_inc;
                     wr_addr_s_reg <= wr_addr_s_reg + 7'd1;
                     state_reg     <= CLEAR;
                  end else begin
                     state_reg <= WR_N;
                  end
`else
                  state_reg <= WR_N;
`endif
               end else begin
                  i_reg           <= i_inc;
                  rd_addr_out_reg <= rd_next_addr;
                  state_reg       <= RD_COEF;
               end
            end

`ifdef STP_CLEAR_UNUSED_EN
            CLEAR: begin
               i_reg         <= i_inc;
               wr_addr_s_reg <= wr_addr_s_reg + 7'd1;
               if (i_reg == 5'(max_degree)) begin
                  state_reg <= WR_N;
               end
            end
`endif

            WR_N: begin
               upd_reg    <= upd_valid;
               status_reg <= 1'b0;
               done_reg   <= 1'b1;
               state_reg  <= DONE;
            end

            DONE: begin
               // A rejected instruction enters DONE straight from CHECK_N and
               // sees done one cycle later; a completed one already had done
               // set by WR_N.
               if (start_stp) begin
                  a_reg     <= A;
                  n_reg     <= N_in;
                  base_reg  <= rd_addr_data;
                  i_reg     <= '0;
                  done_reg  <= 1'b0;
                  state_reg <= CHECK_N;
               end else begin
                  done_reg <= 1'b1;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Enables are decoded straight from the state so each is a one-cycle pulse.
   assign en_rd_data = (state_reg == RD_COEF);
`ifdef STP_CLEAR_UNUSED_EN
   assign en_wr_S    = (state_reg == WR_COEF) || (state_reg == CLEAR);
`else
   assign en_wr_S    = (state_reg == WR_COEF);
`endif
   assign en_wr_N    = (state_reg == WR_N);

   // Write data is a pass-through of the buffer read data, which only becomes
   // valid in WR_COEF; it is zero in every other state (including CLEAR).
   assign wr_data_S  = (state_reg == WR_COEF) ? data_in[word_size-1:0] : '0;

   assign rd_addr_data_out     = rd_addr_out_reg;
   assign rd_addr_data_updated = upd_reg;
   assign wr_addr_S            = wr_addr_s_reg;
   assign wr_addr_N            = a_reg;
   assign wr_data_N            = n_reg;
   assign done_stp             = done_reg;
   assign status               = {31'd0, status_reg};

endmodule

// File: tb/tb_stp_fsm.sv
// -----------------------------------------------------------------------------
// tb_stp_fsm -- self-checking bench for stp_fsm
//
// Models the input data buffer (registered read), captures S and N memory
// writes, and runs a table of instructions back to back, followed by
// hand-written sequences for abort, start-while-busy and async reset.
// -----------------------------------------------------------------------------
module tb_stp_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_instr = 1'b1;
   logic        start_stp = 1'b0;
   logic [2:0]  A = '0;
   logic [4:0]  N_in = '0;
   logic [9:0]  rd_addr_data = '0;
   logic [31:0] data_in = '0;
   logic        en_rd_data;
   logic [9:0]  rd_addr_data_out;
   logic [9:0]  rd_addr_data_updated;
   logic        en_wr_S;
   logic [6:0]  wr_addr_S;
   logic [15:0] wr_data_S;
   logic        en_wr_N;
   logic [2:0]  wr_addr_N;
   logic [4:0]  wr_data_N;
   logic        done_stp;
   logic [31:0] status;

   stp_fsm dut (
      .clk                  (clk),
      .rst                  (rst),
      .rst_instr            (rst_instr),
      .start_stp            (start_stp),
      .A                    (A),
      .N_in                 (N_in),
      .rd_addr_data         (rd_addr_data),
      .data_in              (data_in),
      .en_rd_data           (en_rd_data),
      .rd_addr_data_out     (rd_addr_data_out),
      .rd_addr_data_updated (rd_addr_data_updated),
      .en_wr_S              (en_wr_S),
      .wr_addr_S            (wr_addr_S),
      .wr_data_S            (wr_data_S),
      .en_wr_N              (en_wr_N),
      .wr_addr_N            (wr_addr_N),
      .wr_data_N            (wr_data_N),
      .done_stp             (done_stp),
      .status               (status)
   );

   always #5 clk = ~clk;

   // Buffer, captured memories and their expected images.
   logic [31:0] buffer [1024];
   logic [15:0] s_act [128] = '{default: '0};
   logic [4:0]  n_act [8]   = '{default: '0};
   logic [15:0] exp_s [128] = '{default: '0};
   logic [4:0]  exp_n [8]   = '{default: '0};
   int          s_wr_cnt = 0;
   int          n_wr_cnt = 0;

   always @(posedge clk) begin
      if (en_rd_data === 1'b1) data_in <= buffer[rd_addr_data_out];
      if (en_wr_S === 1'b1) begin
         s_act[wr_addr_S] <= wr_data_S;
         s_wr_cnt         <= s_wr_cnt + 1;
      end
      if (en_wr_N === 1'b1) begin
         n_act[wr_addr_N] <= wr_data_N;
         n_wr_cnt         <= n_wr_cnt + 1;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  a;
      logic [4:0]  n;
      logic [9:0]  base;
      int          lat;     // done_stp rise, in edges after the start edge
      logic        st;      // expected status
      logic [9:0]  upd;     // expected rd_addr_data_updated
      logic [15:0] first;   // expected S[a*11]
      logic [15:0] last;    // expected S[a*11+n]
      int          glitch;  // cycle at which a stray start pulse is sent (-1 none)
   } vec_t;

   vec_t vecs [7];

   task automatic mem_compare(input string tag);
      int bad_s;
      int bad_n;
      bad_s = 0;
      bad_n = 0;
      for (int k = 0; k < 88; k++) if (s_act[k] !== exp_s[k]) bad_s++;
      for (int k = 0; k < 8; k++)  if (n_act[k] !== exp_n[k]) bad_n++;
      chk({tag, " s_mem_bad_words"}, 64'(bad_s), 64'd0);
      chk({tag, " n_mem_bad_words"}, 64'(bad_n), 64'd0);
   endtask

   task automatic do_instr(input vec_t v, input string tag);
      int lat;
      int s0;
      int n0;
      int exp_lat;
      int exp_sw;
      int sb;
      s0 = s_wr_cnt;
      n0 = n_wr_cnt;
      sb = int'(v.a) * 11;
      exp_lat = v.lat;
      exp_sw  = v.st ? 0 : int'(v.n) + 1;
`ifdef STP_CLEAR_UNUSED_EN
      if (!v.st) begin
         exp_lat = exp_lat + (10 - int'(v.n));
         exp_sw  = 11;
      end
`endif
      @(negedge clk);
      start_stp    = 1'b1;
      A            = v.a;
      N_in         = v.n;
      rd_addr_data = v.base;
      @(negedge clk);
      start_stp = 1'b0;
      lat = 0;
      while (done_stp !== 1'b1 && lat < 300) begin
         if (lat == v.glitch) begin
            start_stp    = 1'b1;
            A            = ~v.a;
            N_in         = 5'd0;
            rd_addr_data = '0;
         end else begin
            start_stp = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start_stp = 1'b0;
      $display("instr %s a=%0d n=%0d base=%0d lat=%0d status=%0d upd=%0d",
               tag, v.a, v.n, v.base, lat, status, rd_addr_data_updated);
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, " status"}, 64'(status), 64'(v.st));
      chk({tag, " upd"}, 64'(rd_addr_data_updated), 64'(v.upd));
      chk({tag, " s_writes"}, 64'(s_wr_cnt - s0), 64'(exp_sw));
      chk({tag, " n_writes"}, 64'(n_wr_cnt - n0), v.st ? 64'd0 : 64'd1);
      if (!v.st) begin
         chk({tag, " s_first"}, 64'(s_act[sb]), 64'(v.first));
         chk({tag, " s_last"}, 64'(s_act[sb + int'(v.n)]), 64'(v.last));
         for (int j = 0; j <= int'(v.n); j++)
            exp_s[sb + j] = buffer[(int'(v.base) + j) % 1024][15:0];
`ifdef STP_CLEAR_UNUSED_EN
         for (int j = int'(v.n) + 1; j <= 10; j++) exp_s[sb + j] = 16'd0;
`endif
         exp_n[v.a] = v.n;
      end
      @(negedge clk);
      chk({tag, " done_hold"}, 64'(done_stp), 64'd1);
      mem_compare(tag);
   endtask

   int s0;
   int n0;

   initial begin
      for (int k = 0; k < 1024; k++) buffer[k] = {16'hA5A5, 16'(k)};
      buffer[1]    = 32'h0001_6358;   // low half 25432
      for (int j = 0; j < 11; j++) buffer[100 + j] = 32'hFFFF_0000 | 32'(j + 1);
      buffer[1023] = 32'h1234_0005;
      buffer[0]    = 32'h0007_0006;

      //              a     n      base     lat st    upd      first      last     glitch
      vecs[0] = '{3'd1, 5'd0,  10'd1,    4, 1'b0, 10'd2,   16'd25432, 16'd25432, -1};
      vecs[1] = '{3'd7, 5'd10, 10'd100, 24, 1'b0, 10'd111, 16'd1,     16'd11,    -1};
      vecs[2] = '{3'd3, 5'd11, 10'd200,  2, 1'b1, 10'd200, 16'd0,     16'd0,     -1};
      vecs[3] = '{3'd2, 5'd1,  10'd1023, 6, 1'b0, 10'd1,   16'd5,     16'd6,     -1};
      vecs[4] = '{3'd0, 5'd2,  10'd500,  8, 1'b0, 10'd503, 16'd500,   16'd502,    2};
      vecs[5] = '{3'd6, 5'd9,  10'd1020,22, 1'b0, 10'd6,   16'd1020,  16'd5,     -1};
      vecs[6] = '{3'd5, 5'd31, 10'd7,    2, 1'b1, 10'd7,   16'd0,     16'd0,     -1};

      // Reset state, while rst is held and just after release.
      #1;
      chk("reset_outs_any", 64'(|{en_rd_data, rd_addr_data_out, rd_addr_data_updated, en_wr_S,
                                  wr_addr_S, wr_data_S, en_wr_N, wr_addr_N, wr_data_N,
                                  done_stp, status}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_done", 64'(done_stp), 64'd0);
      chk("idle_upd", 64'(rd_addr_data_updated), 64'd0);

      for (int v = 0; v < 7; v++) do_instr(vecs[v], $sformatf("vec%0d", v));

      // Abort during the second RD_COEF of an N=3 instruction.
      s0 = s_wr_cnt;
      n0 = n_wr_cnt;
      @(negedge clk);
      start_stp = 1'b1; A = 3'd4; N_in = 5'd3; rd_addr_data = 10'd300;
      @(negedge clk);
      start_stp = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort pre en_rd", 64'(en_rd_data), 64'd1);
      chk("abort pre rd_addr", 64'(rd_addr_data_out), 64'd301);
      rst_instr = 1'b0;
      @(negedge clk);
      $display("instr abort a=4 n=3 base=300 done=%0d status=%0d upd=%0d",
               done_stp, status, rd_addr_data_updated);
      chk("abort outs_any", 64'(|{en_rd_data, en_wr_S, en_wr_N, done_stp, status}), 64'd0);
      chk("abort upd", 64'(rd_addr_data_updated), 64'd7);
      rst_instr = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort done_stays_low", 64'(done_stp), 64'd0);
      chk("abort s_writes", 64'(s_wr_cnt - s0), 64'd1);
      chk("abort n_writes", 64'(n_wr_cnt - n0), 64'd0);
      exp_s[44] = 16'd300;
      mem_compare("abort");

      // Asynchronous reset between edges while in WR_COEF.
      s0 = s_wr_cnt;
      @(negedge clk);
      start_stp = 1'b1; A = 3'd3; N_in = 5'd2; rd_addr_data = 10'd40;
      @(negedge clk);
      start_stp = 1'b0;
      repeat (2) @(negedge clk);
      chk("arst pre en_wr_S", 64'(en_wr_S), 64'd1);
      chk("arst pre wr_addr_S", 64'(wr_addr_S), 64'd33);
      chk("arst pre wr_data_S", 64'(wr_data_S), 64'd40);
      #2 rst = 1'b1;
      #1;
      $display("instr async_reset a=3 n=2 base=40 en_wr_S=%0d done=%0d", en_wr_S, done_stp);
      chk("arst outs_any", 64'(|{en_rd_data, rd_addr_data_out, rd_addr_data_updated, en_wr_S,
                                 wr_addr_S, wr_data_S, en_wr_N, wr_addr_N, wr_data_N,
                                 done_stp, status}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("arst idle en_rd", 64'(en_rd_data), 64'd0);
      chk("arst s_writes", 64'(s_wr_cnt - s0), 64'd0);

      // Recovery from IDLE after reset.
      do_instr(vecs[0], "recover");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run cannot hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
